commit_unit: RTL
================

Name: commit_unit

Overview:
- Result-side counterpart of the execution ALUs: it collects completed results from N execution units' committer interfaces.
- It arbitrates one result per cycle and writes it to the register file.
- It pulses `clear` back to the granted unit, releases the destination register in the scoreboard, and converts unit error flags into a halting exception.
- Sits between the execution units and the register file / scoreboard.

Parameters:
- N_UNITS, 4, number of execution units feeding the committer (≥2, power of two).
- XLEN, core_config_pkg::XLEN (32), result data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), register address width.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- u_res  in  N_UNITS*XLEN  unit results, unit i at bits [i*XLEN +: XLEN]
- u_rd  in  N_UNITS*REG_ADDR_W  unit destination registers
- u_valid  in  N_UNITS  unit i holds a result
- u_error  in  N_UNITS  unit i result is erroneous (overflow/unknown op)
- u_req  in  N_UNITS  unit i requests priority commit
- u_clear  out  N_UNITS  one-cycle pulse releasing unit i
- wb_ready  in  1  register-file write port available this cycle
- wb_en  out  1  register-file write strobe
- wb_addr  out  REG_ADDR_W  write address
- wb_data  out  XLEN  write data
- rel_valid  out  1  scoreboard release strobe
- rel_rd  out  REG_ADDR_W  register released
- exc_valid  out  1  exception pending (level)
- exc_unit  out  $clog2(N_UNITS)  unit that raised it
- exc_rd  out  REG_ADDR_W  destination of the faulting result
- exc_ack  in  1  exception acknowledged

Behaviour:
- Reset (rst=1 at a posedge): every output is 0, state=RUN, rr_ptr=N_UNITS-1, pend_mask=0.
  - Reset mid-operation drops any in-flight grant; no clear is issued for it.
- Eligibility: `elig[i] = u_valid[i] & ~pend_mask[i]`.
  - No grant is made if state≠RUN or wb_ready=0.
- Arbitration (combinational, cycle t):
  - If any `elig & u_req`, grant the lowest such index.
  - Else grant the first eligible index searching upward from rr_ptr+1, with wrap-around.
  - rr_ptr ← granted index on every grant.
- Latency: a grant in cycle t produces registered outputs in cycle t+1.
  - u_clear[g]=1 for exactly one cycle.
  - rel_valid=1, rel_rd=u_rd[g].
  - pend_mask[g]=1 during t+1, so unit g (whose valid is still high until its clear edge) cannot be re-granted in t+1. The mask bit falls after one cycle.
- Normal result (u_error[g]=0): at t+1, wb_en=1 only if u_rd[g]≠0, with wb_addr=u_rd[g] and wb_data=u_res[g].
  - rd=0 writes are suppressed, but clear and release still occur.
- Error result (u_error[g]=1): at t+1, wb_en=0 and rel_valid=1.
  - exc_valid=1, exc_unit=g, exc_rd=u_rd[g].
  - State → HALT.
- FSM:
  - RUN: grants allowed; an error grant → HALT.
  - HALT: no grants; exc_valid held with exc_unit/exc_rd stable. exc_ack=1 → RUN next cycle with exc_valid=0; grants may resume in that same cycle.
  - exc_ack while in RUN is ignored.
- Outputs when no grant: wb_en=0, rel_valid=0, u_clear=0. wb_addr/wb_data hold their last value.
- Simultaneous events:
  - u_req and round-robin contend: u_req wins.
  - Error and u_req on different units: only the granted unit is processed.
  - wb_ready falling does not cancel an already-registered t+1 output.
- At most one wb_en per cycle; sustained throughput is 1 result/cycle when ≥2 units alternate.

Decomposition:
- core_config_pkg additions:
  - `commit_state_t` enum {RUN, HALT}.
  - `N_EXEC_UNITS` constant.
  - `UNIT_ID_W = $clog2(N_EXEC_UNITS)`.
- Sub-module rr_arbiter (N-bit request vector, priority vector, pointer in; one-hot grant plus index out; purely combinational) is instantiated once.
- FSM, pend_mask and output registers live in commit_unit.

Test Plan:
1. u_valid=0001, u_res[0]=0x000000AA, u_rd[0]=5, wb_ready=1 → next cycle: wb_en=1, wb_addr=5, wb_data=0xAA, u_clear=0001 for 1 cycle, rel_valid=1, rel_rd=5.
2. u_valid=1111 held, each unit dropping valid the cycle after its clear and re-raising 2 cycles later → grant order 0,1,2,3,0,…; no unit cleared in two consecutive cycles; wb_en high every cycle.
3. u_valid=0111, u_req=0100 → first grant is unit 2, then round-robin continues 0,1.
4. u_valid=0010, u_rd[1]=0, u_res[1]=0xFFFFFFFF → wb_en=0, u_clear=0010, rel_valid=1, rel_rd=0.
5. u_valid=0011, u_error[0]=1, u_rd[0]=7 → wb_en=0, exc_valid=1, exc_unit=0, exc_rd=7.
   - Unit 1 is not granted until exc_ack=1; the grant happens in the cycle exc_ack is seen, and the write appears the cycle after.
6. wb_ready=0 with u_valid=1111 → no u_clear/wb_en for 5 cycles. Then assert rst mid-stream → all outputs 0 next cycle, state RUN, first post-reset grant is unit 0.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the execution and commit stages.
// Provides the data/register widths, the execution unit count, the unit-id
// width derived from it, and the commit-stage FSM state type.
package core_config_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned N_EXEC_UNITS = 4;
  localparam int unsigned UNIT_ID_W    = $clog2(N_EXEC_UNITS);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } commit_state_t;

endpackage

// File: rtl/commit_unit_rr_arbiter.sv
// rr_arbiter: purely combinational arbiter with a priority override.
//   req_i     : N-bit request vector
//   prio_i    : N-bit priority vector; the lowest index with req & prio wins
//   ptr_i     : last granted index; otherwise the search starts at ptr_i+1
//               and wraps around
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester
//   gnt_any_o : a grant was made
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         prio_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_any_o
);

  localparam int unsigned IDX_W = $clog2(N);

  logic             found;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && prio_i[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    // N is a power of two, so the IDX_W-bit add wraps naturally; k == N
    // lands back on ptr_i itself as the last candidate.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ptr_i + IDX_W'(k);
      if (!found && req_i[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[idx] = 1'b1;
  end

  assign gnt_idx_o = idx;
  assign gnt_any_o = found;

endmodule

// File: rtl/commit_unit.sv
// commit_unit: collects completed results from N execution units, grants one
// per cycle, writes it to the register file, pulses u_clear to the granted
// unit, releases its destination in the scoreboard, and turns a unit error
// into a halting exception held until exc_ack.
//   clk, rst            : clock, synchronous active-high reset
//   u_res/u_rd          : packed per-unit result data / destination register
//   u_valid/u_error     : per-unit result present / result erroneous
//   u_req               : per-unit priority commit request
//   u_clear             : one-cycle release pulse to the granted unit
//   wb_ready            : register-file write port available
//   wb_en/wb_addr/wb_data : register-file write
//   rel_valid/rel_rd    : scoreboard release
//   exc_valid/exc_unit/exc_rd : pending exception (level), exc_ack clears it
module commit_unit #(
  parameter int unsigned N_UNITS    = core_config_pkg::N_EXEC_UNITS,
  parameter int unsigned XLEN       = core_config_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_UNITS*XLEN-1:0]       u_res,
  input  logic [N_UNITS*REG_ADDR_W-1:0] u_rd,
  input  logic [N_UNITS-1:0]            u_valid,
  input  logic [N_UNITS-1:0]            u_error,
  input  logic [N_UNITS-1:0]            u_req,
  output logic [N_UNITS-1:0]            u_clear,
  input  logic                          wb_ready,
  output logic                          wb_en,
  output logic [REG_ADDR_W-1:0]         wb_addr,
  output logic [XLEN-1:0]               wb_data,
  output logic                          rel_valid,
  output logic [REG_ADDR_W-1:0]         rel_rd,
  output logic                          exc_valid,
  output logic [$clog2(N_UNITS)-1:0]    exc_unit,
  output logic [REG_ADDR_W-1:0]         exc_rd,
  input  logic                          exc_ack
);

  import core_config_pkg::*;

  localparam int unsigned ID_W = $clog2(N_UNITS);

  commit_state_t       state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [N_UNITS-1:0]  pend_q;

  logic [XLEN-1:0]       res_a [N_UNITS];
  logic [REG_ADDR_W-1:0] rd_a  [N_UNITS];

  for (genvar i = 0; i < N_UNITS; i++) begin : g_unpack
    assign res_a[i] = u_res[i*XLEN +: XLEN];
    assign rd_a[i]  = u_rd[i*REG_ADDR_W +: REG_ADDR_W];
  end

  // An acknowledge seen while halted lets arbitration resume in that same
  // cycle rather than waiting for the state register to return to RUN.
  logic               can_grant;
  logic [N_UNITS-1:0] arb_req;
  logic [N_UNITS-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  assign can_grant = wb_ready & ((state_q == RUN) | exc_ack);
  assign arb_req   = can_grant ? (u_valid & ~pend_q) : '0;

  rr_arbiter #(
    .N (N_UNITS)
  ) u_arb (
    .req_i     (arb_req),
    .prio_i    (u_req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  logic [XLEN-1:0]       g_res;
  logic [REG_ADDR_W-1:0] g_rd;
  logic                  g_err;

  assign g_res = res_a[gnt_idx];
  assign g_rd  = rd_a[gnt_idx];
  assign g_err = u_error[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      rr_ptr_q  <= ID_W'(N_UNITS - 1);
      pend_q    <= '0;
      u_clear   <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      rel_valid <= 1'b0;
      rel_rd    <= '0;
      exc_valid <= 1'b0;
      exc_unit  <= '0;
      exc_rd    <= '0;
    end else begin
      wb_en     <= 1'b0;
      rel_valid <= 1'b0;
      u_clear   <= '0;
      // Masks the granted unit for exactly the cycle its clear is visible,
      // while its valid is still high.
      pend_q    <= gnt;

      if (state_q == HALT && exc_ack) begin
        state_q   <= RUN;
        exc_valid <= 1'b0;
      end

      if (gnt_any) begin
        rr_ptr_q  <= gnt_idx;
        u_clear   <= gnt;
        rel_valid <= 1'b1;
        rel_rd    <= g_rd;
        if (g_err) begin
          state_q   <= HALT;
          exc_valid <= 1'b1;
          exc_unit  <= gnt_idx;
          exc_rd    <= g_rd;
        end else if (g_rd != '0) begin
          wb_en   <= 1'b1;
          wb_addr <= g_rd;
          wb_data <= g_res;
        end
      end
    end
  end

endmodule
